// File: rtl/sample_mem_dump_reader_pkg.sv
// Shared definitions for the sample memory dump reader: the dump FSM encoding and
// the default frame start marker.
package sample_mem_dump_reader_pkg;

  localparam logic [7:0] HeaderByteDefault = 8'hA5;

  typedef enum logic [2:0] {
    DumpIdle     = 3'd0,
    DumpHeader   = 3'd1,
    DumpReadReq  = 3'd2,
    DumpReadWait = 3'd3,
    DumpSend     = 3'd4,
    DumpDone     = 3'd5
  } dump_state_e;

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one memory word and presents it one byte at a time, MSB first, advancing
// on each accepted byte and flagging the final byte of the word.
module word_byte_serializer #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] word_i,
  input  logic                 shift_i,
  output logic [7:0]           byte_o,
  output logic                 last_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  logic [DataWidth-1:0] shift_q, shift_d;
  logic [IdxW-1:0]      idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (load_i) begin
      shift_d = word_i;
      idx_d   = '0;
    end else if (shift_i) begin
      shift_d = shift_q << 8;
      idx_d   = idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign byte_o = shift_q[DataWidth-1 -: 8];
  assign last_o = (idx_q == IdxW'(NumBytes - 1));

endmodule

// File: rtl/sample_mem_dump_reader.sv
// Streams a header byte followed by N words of sample memory, MSB first, to a
// byte-wide transmitter with valid/ready flow control, then waits for a host ack.
module sample_mem_dump_reader
  import sample_mem_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [7:0]  HEADER_BYTE = HeaderByteDefault
) (
  input  logic                  iClock,
  input  logic                  iResetN,
  input  logic                  iStartDump,
  input  logic [ADDR_WIDTH:0]   iWordsToDump,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic                  oMemRead,
  input  logic [DATA_WIDTH-1:0] iMemData,
  output logic [7:0]            oTxData,
  output logic                  oTxValid,
  input  logic                  iTxReady,
  output logic                  oBusy,
  output logic                  oDumpDone,
  input  logic                  iDumpDoneAck
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [CntW-1:0]       sent_q, sent_d;

  logic       ser_load, ser_shift, ser_last;
  logic [7:0] ser_byte;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    sent_d    = sent_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    oMemRead  = 1'b0;
    oTxValid  = 1'b0;
    oTxData   = '0;
    unique case (state_q)
      DumpIdle: begin
        if (iStartDump) begin
          state_d = DumpHeader;
          addr_d  = '0;
          sent_d  = '0;
          // A zero count stands for the whole memory.
          count_d = (iWordsToDump == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : iWordsToDump;
        end
      end
      DumpHeader: begin
        oTxValid = 1'b1;
        oTxData  = HEADER_BYTE;
        if (iTxReady) state_d = DumpReadReq;
      end
      DumpReadReq: begin
        oMemRead = 1'b1;
        state_d  = DumpReadWait;
      end
      DumpReadWait: begin
        ser_load = 1'b1;
        state_d  = DumpSend;
      end
      DumpSend: begin
        oTxValid = 1'b1;
        oTxData  = ser_byte;
        if (iTxReady) begin
          ser_shift = 1'b1;
          if (ser_last) begin
            sent_d = sent_q + CntW'(1);
            // The address is only bumped when another word follows, so it never wraps.
            if (sent_d == count_q) begin
              state_d = DumpDone;
            end else begin
              addr_d  = addr_q + ADDR_WIDTH'(1);
              state_d = DumpReadReq;
            end
          end
        end
      end
      DumpDone: begin
        if (iDumpDoneAck) state_d = DumpIdle;
      end
      default: state_d = DumpIdle;
    endcase
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      state_q <= DumpIdle;
      addr_q  <= '0;
      count_q <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      sent_q  <= sent_d;
    end
  end

  word_byte_serializer #(
    .DataWidth(DATA_WIDTH)
  ) u_serializer (
    .clk_i  (iClock),
    .rst_ni (iResetN),
    .load_i (ser_load),
    .word_i (iMemData),
    .shift_i(ser_shift),
    .byte_o (ser_byte),
    .last_o (ser_last)
  );

  assign oMemAddr  = addr_q;
  assign oBusy     = (state_q != DumpIdle);
  assign oDumpDone = (state_q == DumpDone);

endmodule

// File: tb/tb_sample_mem_dump_reader.sv
// Randomized self-checking bench: a memory responder and byte monitor feed a queue
// that is compared with the frame expected from the memory contents.
module tb_sample_mem_dump_reader;

  // Narrow address so the full-memory (count 0) dump fits a short run.
  localparam int AW = 8;
  localparam int NumWords = 1 << AW;

  logic          iClock = 1'b0;
  logic          iResetN = 1'b0;
  logic          iStartDump = 1'b0;
  logic [AW:0]   iWordsToDump = '0;
  logic [AW-1:0] oMemAddr;
  logic          oMemRead;
  logic [31:0]   iMemData = '0;
  logic [7:0]    oTxData;
  logic          oTxValid;
  logic          iTxReady = 1'b1;
  logic          oBusy;
  logic          oDumpDone;
  logic          iDumpDoneAck = 1'b0;

  sample_mem_dump_reader #(
    .ADDR_WIDTH(AW)
  ) dut (
    .iClock      (iClock),
    .iResetN     (iResetN),
    .iStartDump  (iStartDump),
    .iWordsToDump(iWordsToDump),
    .oMemAddr    (oMemAddr),
    .oMemRead    (oMemRead),
    .iMemData    (iMemData),
    .oTxData     (oTxData),
    .oTxValid    (oTxValid),
    .iTxReady    (iTxReady),
    .oBusy       (oBusy),
    .oDumpDone   (oDumpDone),
    .iDumpDoneAck(iDumpDoneAck)
  );

  always #5 iClock = ~iClock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0]   mem [NumWords];
  logic [7:0]    got_q [$];
  int            got_cyc [$];
  logic [7:0]    exp_q [$];
  int            reads = 0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] first_addr = '0;
  int            stall_err = 0;
  bit            prev_stall = 0;
  logic [7:0]    prev_data = '0;

  always @(posedge iClock) cyc <= cyc + 1;

  // Synchronous memory: data only valid the cycle after a read, garbage otherwise.
  always @(posedge iClock) iMemData <= oMemRead ? mem[oMemAddr] : $urandom();

  always @(negedge iClock) begin
    if (!iResetN) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (!oTxValid || oTxData !== prev_data)) stall_err++;
      if (oTxValid && iTxReady) begin
        got_q.push_back(oTxData);
        got_cyc.push_back(cyc);
      end
      if (oMemRead) begin
        if (reads == 0) first_addr = oMemAddr;
        reads++;
        last_addr = oMemAddr;
      end
      prev_stall = oTxValid && !iTxReady;
      prev_data  = oTxData;
    end
  end

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  // Expected frame: header then every word MSB first.
  function automatic void build_exp(input int n);
    int words = (n == 0) ? NumWords : n;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int w = 0; w < words; w++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(mem[w][8*b +: 8]);
  endfunction

  function automatic int first_diff();
    int m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return m;
    return -1;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 8'h00;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 8'h00;
  endfunction

  // mode 0: ready high, 1: ready toggles every 3 cycles, 2: random ready,
  // 3: ready high plus a stray start pulse mid-word.
  task automatic run_dump(input int n, input int mode, output bit timed_out);
    int  k = 0;
    bit  poked = 0;
    got_q.delete();
    got_cyc.delete();
    reads = 0;
    stall_err = 0;
    iTxReady = 1'b1;
    iWordsToDump = n[AW:0];
    iStartDump = 1'b1;
    tick();
    iStartDump = 1'b0;
    iWordsToDump = AW'($urandom());
    timed_out = 1;
    while (k < 20000) begin
      if (oDumpDone) begin
        timed_out = 0;
        break;
      end
      if (mode == 1) iTxReady = ((k / 3) % 2) == 0;
      else if (mode == 2) iTxReady = ($urandom_range(0, 3) != 0);
      else iTxReady = 1'b1;
      iStartDump = (mode == 3) && (got_q.size() == 3) && !poked;
      if (iStartDump) poked = 1;
      tick();
      k++;
    end
    iStartDump = 1'b0;
    iTxReady = 1'b1;
  endtask

  task automatic ack_done();
    iDumpDoneAck = 1'b1;
    tick();
    iDumpDoneAck = 1'b0;
  endtask

  task automatic load_fixed();
    mem[0] = 32'h01020304;
    mem[1] = 32'h11121314;
    mem[2] = 32'h21222324;
  endtask

  task automatic test_reset();
    iResetN = 1'b0;
    iStartDump = 1'b1;
    tick();
    tick();
    checks++;
    if ({oBusy, oTxValid, oMemRead, oDumpDone} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 0000", {oBusy, oTxValid, oMemRead, oDumpDone});
    end
    checks++;
    if (oMemAddr !== '0 || oTxData !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got addr=%h tx=%h required 0/0", oMemAddr, oTxData);
    end
    iStartDump = 1'b0;
    iResetN = 1'b1;
    tick();
    tick();
    checks++;
    if (oBusy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b required 0", oBusy);
    end
  endtask

  task automatic test_basic();
    bit to;
    int d;
    load_fixed();
    run_dump(3, 0, to);
    build_exp(3);
    d = first_diff();
    checks++;
    if (to) begin
      failures++;
      $display("FAIL basic_timeout: got no oDumpDone required oDumpDone=1");
    end
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL basic_bytes: idx %0d got %h (n=%0d) required %h (n=%0d)",
               d, got_at(d), got_q.size(), exp_at(d), exp_q.size());
    end
    checks++;
    if (reads != 3 || oBusy !== 1'b1) begin
      failures++;
      $display("FAIL basic_reads: got reads=%0d busy=%b required 3/1", reads, oBusy);
    end
    ack_done();
    checks++;
    if (oBusy !== 1'b0 || oDumpDone !== 1'b0) begin
      failures++;
      $display("FAIL basic_ack: got busy=%b done=%b required 0/0", oBusy, oDumpDone);
    end
  endtask

  task automatic test_stall();
    bit to;
    int d;
    load_fixed();
    run_dump(3, 1, to);
    build_exp(3);
    d = first_diff();
    checks++;
    if (to || d != -1) begin
      failures++;
      $display("FAIL stall_bytes: timeout=%0d idx %0d got %h required %h", to, d, got_at(d),
               exp_at(d));
    end
    checks++;
    if (stall_err != 0) begin
      failures++;
      $display("FAIL stall_stable: got %0d unstable stalled cycles required 0", stall_err);
    end
    ack_done();
  endtask

  task automatic test_random();
    bit to;
    int d;
    int n;
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(1, 6);
      for (int w = 0; w < n; w++) mem[w] = $urandom();
      run_dump(n, 2, to);
      build_exp(n);
      d = first_diff();
      checks++;
      if (to || d != -1) begin
        failures++;
        $display("FAIL random_bytes[%0d]: timeout=%0d idx %0d got %h required %h", i, to, d,
                 got_at(d), exp_at(d));
      end
      checks++;
      if (reads != n || last_addr !== AW'(n - 1) || stall_err != 0) begin
        failures++;
        $display("FAIL random_reads[%0d]: got reads=%0d last=%h stall=%0d required %0d/%h/0",
                 i, reads, last_addr, stall_err, n, AW'(n - 1));
      end
      ack_done();
    end
  endtask

  task automatic test_full();
    bit to;
    int d;
    for (int w = 0; w < NumWords; w++) mem[w] = $urandom();
    run_dump(0, 0, to);
    build_exp(0);
    d = first_diff();
    checks++;
    if (to || reads != NumWords || last_addr !== {AW{1'b1}}) begin
      failures++;
      $display("FAIL full_reads: timeout=%0d got reads=%0d last=%h required %0d/%h", to, reads,
               last_addr, NumWords, {AW{1'b1}});
    end
    checks++;
    if (got_q.size() != 4 * NumWords + 1 || d != -1) begin
      failures++;
      $display("FAIL full_bytes: got n=%0d idx %0d=%h required n=%0d %h", got_q.size(), d,
               got_at(d), 4 * NumWords + 1, exp_at(d));
    end
    ack_done();
  endtask

  task automatic test_ignore_start();
    bit to;
    int d;
    int nb;
    for (int w = 0; w < 2; w++) mem[w] = $urandom();
    run_dump(2, 3, to);
    build_exp(2);
    d = first_diff();
    checks++;
    if (to || d != -1 || reads != 2) begin
      failures++;
      $display("FAIL ignore_send: timeout=%0d reads=%0d idx %0d got %h required %h", to, reads,
               d, got_at(d), exp_at(d));
    end
    iStartDump = 1'b1;
    tick();
    iStartDump = 1'b0;
    checks++;
    if (oDumpDone !== 1'b1 || oTxValid !== 1'b0) begin
      failures++;
      $display("FAIL ignore_done: got done=%b valid=%b required 1/0", oDumpDone, oTxValid);
    end
    nb = got_q.size();
    iDumpDoneAck = 1'b1;
    iStartDump = 1'b1;
    tick();
    iDumpDoneAck = 1'b0;
    iStartDump = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (oBusy !== 1'b0 || got_q.size() != nb || reads != 2) begin
      failures++;
      $display("FAIL ignore_ack_start: got busy=%b bytes=%0d reads=%0d required 0/%0d/2", oBusy,
               got_q.size(), nb, reads);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int d;
    int k = 0;
    int nb;
    int nr;
    load_fixed();
    got_q.delete();
    got_cyc.delete();
    reads = 0;
    iTxReady = 1'b1;
    iWordsToDump = 3;
    iStartDump = 1'b1;
    tick();
    iStartDump = 1'b0;
    while (got_q.size() < 5 && k < 100) begin
      tick();
      k++;
    end
    checks++;
    if (got_q.size() < 5) begin
      failures++;
      $display("FAIL midreset_reach: got %0d bytes required 5", got_q.size());
    end
    iResetN = 1'b0;
    #1;
    checks++;
    if ({oBusy, oTxValid, oMemRead, oDumpDone, oTxData, oMemAddr} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got busy=%b valid=%b rd=%b done=%b tx=%h addr=%h required 0",
               oBusy, oTxValid, oMemRead, oDumpDone, oTxData, oMemAddr);
    end
    nb = got_q.size();
    nr = reads;
    for (int i = 0; i < 3; i++) tick();
    iResetN = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (got_q.size() != nb || reads != nr || oBusy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet: got bytes=%0d reads=%0d busy=%b required %0d/%0d/0",
               got_q.size(), reads, oBusy, nb, nr);
    end
    mem[0] = $urandom();
    run_dump(1, 0, to);
    build_exp(1);
    d = first_diff();
    checks++;
    if (to || d != -1 || first_addr !== '0) begin
      failures++;
      $display("FAIL midreset_restart: timeout=%0d addr=%h idx %0d got %h required 0 %h", to,
               first_addr, d, got_at(d), exp_at(d));
    end
    ack_done();
  endtask

  task automatic test_latency();
    bit to;
    int d;
    int lat;
    mem[0] = 32'hDEADBEEF;
    run_dump(1, 0, to);
    build_exp(1);
    d = first_diff();
    lat = (got_cyc.size() >= 2) ? got_cyc[1] - got_cyc[0] : -1;
    checks++;
    if (to || d != -1 || reads != 1) begin
      failures++;
      $display("FAIL latency_bytes: timeout=%0d reads=%0d idx %0d got %h required 1 %h", to,
               reads, d, got_at(d), exp_at(d));
    end
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL latency_first: got %0d cycles required 3", lat);
    end
    ack_done();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_latency();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
